// File: rtl/hit_event_logger.sv
// hit_event_logger: timestamps single-cycle hit pulses into a small FIFO,
// keeps a saturating hit counter and a sticky overflow flag.
//
// Handshake: the head entry is offered with ev_valid=1 and ev_ts; it is
// consumed on every rising clk edge where ev_valid=1 and ev_ready=1. While
// ev_valid=1 and ev_ready=0, ev_valid and ev_ts hold their values.
//
// All outputs come straight from registers. ev_ts is a registered copy of
// the next head entry. When the FIFO is empty, or is drained to empty in the
// same cycle as a push, that next head is the pushed value, so it bypasses
// the storage array.
module hit_event_logger #(
    parameter int TSW   = 16,
    parameter int DEPTH = 4,
    parameter int CNTW  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     hit,
    input  logic                     clr,
    output logic                     ev_valid,
    input  logic                     ev_ready,
    output logic [TSW-1:0]           ev_ts,
    output logic [CNTW-1:0]          hit_cnt,
    output logic                     ovf,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [LW-1:0]   LEVEL_FULL = LW'(DEPTH);
    localparam logic [CNTW-1:0] CNT_MAX    = {CNTW{1'b1}};

    logic [TSW-1:0] ts;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [TSW-1:0] mem [DEPTH];

    // Low for the first edge after reset, so that a hit on that edge is ignored.
    logic armed;

    logic            pop;
    logic            full;
    logic            hit_acc;
    logic            push;
    logic            drop;
    logic [LW-1:0]   level_nxt;
    logic [AW-1:0]   rd_ptr_nxt;
    logic [AW-1:0]   wr_ptr_nxt;
    logic [TSW-1:0]  head_nxt;
    logic [CNTW-1:0] cnt_nxt;
    logic            ovf_nxt;

    // Decide push/pop/drop for this cycle and form the next values of the
    // registered outputs.
    always_comb begin
        pop        = 1'b0;
        full       = 1'b0;
        hit_acc    = 1'b0;
        push       = 1'b0;
        drop       = 1'b0;
        level_nxt  = level;
        rd_ptr_nxt = rd_ptr;
        wr_ptr_nxt = wr_ptr;
        head_nxt   = '0;
        cnt_nxt    = hit_cnt;
        ovf_nxt    = ovf;

        pop     = ev_valid & ev_ready;
        full    = (level == LEVEL_FULL);
        hit_acc = hit & armed;
        // A full FIFO still accepts a push if the head leaves in the same cycle.
        push    = hit_acc & (~full | pop);
        drop    = hit_acc & full & ~pop;

        level_nxt  = level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        rd_ptr_nxt = pop  ? rd_ptr + AW'(1) : rd_ptr;
        wr_ptr_nxt = push ? wr_ptr + AW'(1) : wr_ptr;

        // The slot under the next read pointer is being written only when
        // the FIFO ends up holding just the new entry.
        if (push && (wr_ptr == rd_ptr_nxt)) begin
            head_nxt = ts;
        end else begin
            head_nxt = mem[rd_ptr_nxt];
        end

        // Clear restarts the count, and this cycle's hit still counts.
        if (clr) begin
            cnt_nxt = hit_acc ? CNTW'(1) : '0;
        end else if (hit_acc && (hit_cnt != CNT_MAX)) begin
            cnt_nxt = hit_cnt + CNTW'(1);
        end

        // A drop wins over a clear in the same cycle.
        if (drop) begin
            ovf_nxt = 1'b1;
        end else if (clr) begin
            ovf_nxt = 1'b0;
        end
    end

    // Timestamp, pointers, occupancy, flags and registered head output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts       <= '0;
            armed    <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            ev_valid <= 1'b0;
            ev_ts    <= '0;
            hit_cnt  <= '0;
            ovf      <= 1'b0;
        end else begin
            ts       <= ts + TSW'(1);
            armed    <= 1'b1;
            wr_ptr   <= wr_ptr_nxt;
            rd_ptr   <= rd_ptr_nxt;
            level    <= level_nxt;
            ev_valid <= (level_nxt != '0);
            ev_ts    <= head_nxt;
            hit_cnt  <= cnt_nxt;
            ovf      <= ovf_nxt;
        end
    end

    // Event storage. Contents are only meaningful between the pointers, so
    // the array is not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= ts;
        end
    end

endmodule

// File: tb/tb_hit_event_logger.sv
// Bench for hit_event_logger. Two instances share all inputs: A uses the
// default widths, B uses TSW=4 and CNTW=3. A queue-based reference model
// tracks events as absolute cycle numbers; each instance's expected
// timestamp and count are derived from them by truncation and saturation.
module tb_hit_event_logger;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        hit = 1'b0;
    logic        clr = 1'b0;
    logic        ev_ready = 1'b0;

    logic        ev_valid_a, ovf_a;
    logic [15:0] ev_ts_a;
    logic [7:0]  hit_cnt_a;
    logic [2:0]  level_a;

    logic        ev_valid_b, ovf_b;
    logic [3:0]  ev_ts_b;
    logic [2:0]  hit_cnt_b;
    logic [2:0]  level_b;

    hit_event_logger #(.TSW(16), .DEPTH(4), .CNTW(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .hit(hit), .clr(clr),
        .ev_valid(ev_valid_a), .ev_ready(ev_ready), .ev_ts(ev_ts_a),
        .hit_cnt(hit_cnt_a), .ovf(ovf_a), .level(level_a)
    );

    hit_event_logger #(.TSW(4), .DEPTH(4), .CNTW(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .hit(hit), .clr(clr),
        .ev_valid(ev_valid_b), .ev_ready(ev_ready), .ev_ts(ev_ts_b),
        .hit_cnt(hit_cnt_b), .ovf(ovf_b), .level(level_b)
    );

    // Clock.
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    logic [31:0] exp_q[$];
    int          t_m;
    int          cnt_m;
    bit          ovf_m;
    bit          armed_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    // Advance the model by one clock edge given the inputs seen at that edge.
    task automatic model_edge(input bit h, input bit r, input bit c);
        bit pop;
        bit take;
        bit drop;
        pop  = (exp_q.size() > 0) && r;
        take = h && armed_m;
        drop = 1'b0;
        if (pop) void'(exp_q.pop_front());
        if (take) begin
            cnt_m++;
            if (exp_q.size() >= 4) drop = 1'b1;
            else exp_q.push_back(t_m);
        end
        if (c) cnt_m = take ? 1 : 0;
        if (drop) ovf_m = 1'b1;
        else if (c) ovf_m = 1'b0;
        t_m++;
        armed_m = 1'b1;
    endtask

    task automatic compare_all();
        check("valid_a", ev_valid_a, exp_q.size() > 0);
        check("valid_b", ev_valid_b, exp_q.size() > 0);
        check("level_a", level_a, exp_q.size());
        check("level_b", level_b, exp_q.size());
        if (exp_q.size() > 0) begin
            check("ts_a", ev_ts_a, exp_q[0] & 32'hffff);
            check("ts_b", ev_ts_b, exp_q[0] & 32'hf);
        end
        check("cnt_a", hit_cnt_a, sat(cnt_m, 255));
        check("cnt_b", hit_cnt_b, sat(cnt_m, 7));
        check("ovf_a", ovf_a, ovf_m);
        check("ovf_b", ovf_b, ovf_m);
    endtask

    // Driver: apply inputs at the falling edge, check #1 after the rising edge.
    task automatic step(input bit h, input bit r, input bit c);
        hit = h; ev_ready = r; clr = c;
        @(posedge clk);
        model_edge(h, r, c);
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic idle_until(input int target, input bit r);
        while (t_m < target) step(1'b0, r, 1'b0);
    endtask

    // Reset is asserted between edges; outputs must clear before any edge.
    task automatic do_reset();
        hit = 1'b0; clr = 1'b0; ev_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_valid_a", ev_valid_a, 0);
        check("rst_valid_b", ev_valid_b, 0);
        check("rst_level_a", level_a, 0);
        check("rst_level_b", level_b, 0);
        check("rst_cnt_a", hit_cnt_a, 0);
        check("rst_cnt_b", hit_cnt_b, 0);
        check("rst_ovf_a", ovf_a, 0);
        check("rst_ovf_b", ovf_b, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        t_m = 0; cnt_m = 0; ovf_m = 1'b0; armed_m = 1'b0;
    endtask

    initial begin
        @(negedge clk);

        // First edge after reset ignores a hit; the next one captures ts=1.
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        check("first_edge_level", level_a, 0);
        check("first_edge_cnt", hit_cnt_a, 0);
        step(1'b1, 1'b0, 1'b0);
        check("second_edge_ts", ev_ts_a, 1);

        // Single hit at ts=5 with the consumer ready.
        do_reset();
        idle_until(5, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        check("single_valid", ev_valid_a, 1);
        check("single_ts", ev_ts_a, 5);
        check("single_level", level_a, 1);
        step(1'b0, 1'b1, 1'b0);
        check("single_gone", ev_valid_a, 0);
        check("single_cnt", hit_cnt_a, 1);

        // Overflow: five hits at ts=10..14 into a stalled FIFO.
        do_reset();
        idle_until(10, 1'b0);
        repeat (5) step(1'b1, 1'b0, 1'b0);
        check("ovf_level", level_a, 4);
        check("ovf_flag", ovf_a, 1);
        check("ovf_cnt", hit_cnt_a, 5);
        for (int i = 0; i < 4; i++) begin
            check("ovf_drain_ts", ev_ts_a, 10 + i);
            step(1'b0, 1'b1, 1'b0);
        end
        check("ovf_drained", level_a, 0);

        // Full FIFO with a pop and a hit at ts=20 in the same cycle.
        do_reset();
        idle_until(16, 1'b0);
        repeat (4) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("fullpop_level", level_a, 4);
        check("fullpop_ovf", ovf_a, 0);
        for (int i = 0; i < 4; i++) begin
            check("fullpop_drain_ts", ev_ts_a, 17 + i);
            step(1'b0, 1'b1, 1'b0);
        end

        // Backpressure and timestamp wrap on the 4-bit instance.
        do_reset();
        idle_until(15, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            check("hold_ts_b", ev_ts_b, 15);
            step(1'b0, 1'b0, 1'b0);
        end
        check("hold_ts_b", ev_ts_b, 15);
        step(1'b1, 1'b1, 1'b0);
        check("wrap_ts_b", ev_ts_b, 2);
        check("wrap_ts_a", ev_ts_a, 18);

        // Clear together with a hit that is not dropped.
        do_reset();
        step(1'b0, 1'b0, 1'b0);
        repeat (5) step(1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b1, 1'b0);
        repeat (2) step(1'b1, 1'b0, 1'b0);
        check("pre_clr_cnt", hit_cnt_a, 7);
        check("pre_clr_ovf", ovf_a, 1);
        check("pre_clr_level", level_a, 3);
        step(1'b1, 1'b0, 1'b1);
        check("clr_cnt_a", hit_cnt_a, 1);
        check("clr_cnt_b", hit_cnt_b, 1);
        check("clr_ovf", ovf_a, 0);
        check("clr_level", level_a, 4);

        // Saturation of the 3-bit counter, then reset mid-stream.
        do_reset();
        step(1'b0, 1'b0, 1'b0);
        repeat (9) step(1'b1, 1'b1, 1'b0);
        check("sat_cnt_b", hit_cnt_b, 7);
        check("sat_cnt_a", hit_cnt_a, 9);
        repeat (3) step(1'b1, 1'b0, 1'b0);
        do_reset();

        // Randomized traffic with occasional clears and resets.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            step($urandom_range(0, 99) < 45, $urandom_range(0, 99) < 50,
                 $urandom_range(0, 99) < 5);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
